// File: rtl/hazard_ctrl_pkg.sv
// Shared stall-bus layout, stall patterns, hazard-cause encodings and reset polarity
// for the hazard controller and its scoreboard.
package hazard_ctrl_pkg;

  typedef logic [5:0] StallBus;

  localparam int StallBitPc  = 0;
  localparam int StallBitIf  = 1;
  localparam int StallBitId  = 2;
  localparam int StallBitEx  = 3;
  localparam int StallBitMem = 4;
  localparam int StallBitWb  = 5;

  localparam StallBus StallNone = 6'b000000;
  localparam StallBus StallRaw  = 6'b000111;
  localparam StallBus StallEx   = 6'b001111;

  typedef enum logic [1:0] {
    HzRun    = 2'd0,
    HzRaw    = 2'd1,
    HzExBusy = 2'd2
  } hz_state_e;

  localparam logic RstEnable = 1'b0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register pending-write counters: incremented at issue, decremented at write-back,
// with two combinational busy lookups and a sticky overflow/underflow flag.
module hz_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM = 16,
  parameter int WB_LAT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue,
  input  logic [$clog2(REG_NUM)-1:0] issue_addr,
  input  logic                       retire,
  input  logic [$clog2(REG_NUM)-1:0] retire_addr,
  input  logic [$clog2(REG_NUM)-1:0] rd1_addr,
  input  logic [$clog2(REG_NUM)-1:0] rd2_addr,
  output logic                       rd1_busy,
  output logic                       rd2_busy,
  output logic                       err
);

  localparam int AW = $clog2(REG_NUM);
  localparam int CW = $clog2(WB_LAT + 1);

  logic [CW-1:0]      pend [REG_NUM];
  logic [REG_NUM-1:0] inc_hit;
  logic [REG_NUM-1:0] dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      inc_hit[i] = issue  && (issue_addr  == AW'(i));
      dec_hit[i] = retire && (retire_addr == AW'(i));
    end
  end

  // An issue and a retire hitting the same register cancel out and never flag an error.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) pend[i] <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (inc_hit[i] && !dec_hit[i]) begin
          if (pend[i] == CW'(WB_LAT)) err <= 1'b1;
          else                        pend[i] <= pend[i] + CW'(1);
        end else if (dec_hit[i] && !inc_hit[i]) begin
          if (pend[i] == '0) err <= 1'b1;
          else               pend[i] <= pend[i] - CW'(1);
        end
      end
    end
  end

  assign rd1_busy = (pend[rd1_addr] != '0);
  assign rd2_busy = (pend[rd2_addr] != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side stall controller: RAW detection against the scoreboard, stall priority,
// registered stall cause, stall-cycle counter and deadlock watchdog.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM   = 16,
  parameter int WB_LAT    = 3,
  parameter int MAX_STALL = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read,
  input  logic [3:0]  id_reg1_addr,
  input  logic        id_reg2_read,
  input  logic [3:0]  id_reg2_addr,
  input  logic        id_wreg,
  input  logic [3:0]  id_wd,
  input  logic        wb_wreg,
  input  logic [3:0]  wb_wd,
  input  logic        ex_stallreq,
  output logic [5:0]  stall,
  output logic        hazard,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic        deadlock,
  output logic        sb_err
);

  localparam int WdW = $clog2(MAX_STALL + 1);

  logic           busy1;
  logic           busy2;
  logic           sb_issue;
  logic [WdW-1:0] wd_cnt;
  hz_state_e      state_q;

  hz_scoreboard #(.REG_NUM(REG_NUM), .WB_LAT(WB_LAT)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue       (sb_issue),
    .issue_addr  (id_wd),
    .retire      (wb_wreg),
    .retire_addr (wb_wd),
    .rd1_addr    (id_reg1_addr),
    .rd2_addr    (id_reg2_addr),
    .rd1_busy    (busy1),
    .rd2_busy    (busy2),
    .err         (sb_err)
  );

  // Registered counts only: a write-back in this same cycle does not clear the hazard.
  always_comb begin
    hazard = (rst != RstEnable) &&
             ((id_reg1_read && busy1) || (id_reg2_read && busy2));
  end

  always_comb begin
    stall = StallNone;
    if (rst != RstEnable) begin
      if (ex_stallreq) stall = StallEx;
      else if (hazard) stall = StallRaw;
    end
  end

  assign sb_issue = (rst != RstEnable) && !stall[StallBitId] && id_wreg;

  // Deadlock latches on the edge where the run of pure RAW stalls reaches MAX_STALL.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= HzRun;
      stall_cnt <= 16'd0;
      wd_cnt    <= '0;
      deadlock  <= 1'b0;
    end else begin
      if (ex_stallreq) state_q <= HzExBusy;
      else if (hazard) state_q <= HzRaw;
      else             state_q <= HzRun;

      if (stall != StallNone) stall_cnt <= sat_inc16(stall_cnt);

      if (hazard && !ex_stallreq) begin
        if (wd_cnt != WdW'(MAX_STALL)) wd_cnt <= wd_cnt + WdW'(1);
        if (wd_cnt == WdW'(MAX_STALL - 1)) deadlock <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  assign state = state_q;

endmodule
